// File: rtl/sample_fetcher_pkg.sv
// Shared types and constants for the sample fetcher.
//   state_e         : fetch FSM states
//   MinPeriodOffset : added to READ_LATENCY to form the minimum strobe period
package sample_fetcher_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStrobe,
    StWait,
    StHold,
    StGap
  } state_e;

  // STROBE + (READ_LATENCY+1) WAIT cycles + HOLD + GAP: the shortest loop
  // that still leaves o_next low for at least one cycle between pulses.
  localparam int unsigned MinPeriodOffset = 4;

endpackage

// File: rtl/sample_fetcher_timer.sv
// Strobe period timer.
// Loads the clamped period on each STROBE entry and counts down to zero;
// o_elapsed is high once the period has run out (and out of reset).
// Ports:
//   i_clock   : clock, rising edge
//   i_reset   : asynchronous active-low reset
//   i_load    : load the (clamped) period this cycle
//   i_period  : requested period in cycles, sampled only on i_load
//   o_elapsed : period since last load has elapsed
module sample_fetcher_timer
  import sample_fetcher_pkg::*;
#(
  parameter int unsigned PERIOD_WIDTH = 16,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_load,
  input  logic [PERIOD_WIDTH-1:0] i_period,
  output logic                    o_elapsed
);

  localparam logic [PERIOD_WIDTH-1:0] MinPeriod = PERIOD_WIDTH'(READ_LATENCY + MinPeriodOffset);

  logic [PERIOD_WIDTH-1:0] period_eff;
  logic [PERIOD_WIDTH-1:0] count_q, count_d;

  always_comb begin
    period_eff = (i_period < MinPeriod) ? MinPeriod : i_period;
  end

  // Loaded with period-1 so the count hits zero in the last cycle before
  // the next strobe is due; the FSM then enters STROBE exactly on time.
  always_comb begin
    count_d = count_q;
    if (i_load) begin
      count_d = period_eff - PERIOD_WIDTH'(1);
    end else if (count_q != '0) begin
      count_d = count_q - PERIOD_WIDTH'(1);
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_elapsed = (count_q == '0);

endmodule

// File: rtl/sample_fetcher.sv
// Sample fetcher: paces an upstream memory reader with a one-cycle o_next
// strobe every i_period cycles, captures the reader's reference/error words
// after the read latency, and offers them downstream with a valid/ready
// handshake.
// Optional feature: define SAMPLE_FETCHER_ERRACC_EN to add o_err_acc, a running
// sum of o_error over handshakes, restarting at the index-0 sample.
// Ports:
//   i_clock, i_reset          : clock (rising) and async active-low reset
//   i_enable                  : level, run the fetch loop
//   i_period                  : cycles between strobe starts (clamped)
//   o_next                    : advance strobe to the reader
//   i_reference, i_error      : reader data words
//   o_valid, i_ready          : output handshake
//   o_reference, o_error      : captured sample
//   o_index                   : memory index of the captured sample
//   o_last                    : o_valid for the final index DATA_DEPTH
//   o_busy                    : FSM not idle
//   o_err_acc                 : (SAMPLE_FETCHER_ERRACC_EN only) error accumulator
module sample_fetcher
  import sample_fetcher_pkg::*;
#(
  parameter int unsigned DATA_SIZE    = 64,
  parameter int unsigned DATA_DEPTH   = 7514,
  parameter int unsigned ADDR_MODULE  = 13,
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned PERIOD_WIDTH = 16
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_enable,
  input  logic [PERIOD_WIDTH-1:0] i_period,
  output logic                    o_next,
  input  logic [DATA_SIZE-1:0]    i_reference,
  input  logic [DATA_SIZE-1:0]    i_error,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [DATA_SIZE-1:0]    o_reference,
  output logic [DATA_SIZE-1:0]    o_error,
  output logic [ADDR_MODULE-1:0]  o_index,
  output logic                    o_last,
  output logic                    o_busy
`ifdef SAMPLE_FETCHER_ERRACC_EN
  ,
  output logic [DATA_SIZE+ADDR_MODULE-1:0] o_err_acc
`endif
);

  localparam int unsigned WaitW = $clog2(READ_LATENCY + 2);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(READ_LATENCY);
  localparam logic [ADDR_MODULE-1:0] LastIndex = ADDR_MODULE'(DATA_DEPTH);

  state_e                 state_q, state_d;
  logic                   first_q, first_d;
  logic [ADDR_MODULE-1:0] idx_q, idx_d;
  logic [WaitW-1:0]       wait_cnt_q, wait_cnt_d;
  logic                   valid_q, valid_d;
  logic [DATA_SIZE-1:0]   ref_q, err_q;
  logic [ADDR_MODULE-1:0] oidx_q;
  logic                   capture;
  logic                   timer_load;
  logic                   timer_elapsed;

  sample_fetcher_timer #(
    .PERIOD_WIDTH (PERIOD_WIDTH),
    .READ_LATENCY (READ_LATENCY)
  ) u_timer (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_load    (timer_load),
    .i_period  (i_period),
    .o_elapsed (timer_elapsed)
  );

  always_comb begin
    state_d    = state_q;
    first_d    = first_q;
    idx_d      = idx_q;
    wait_cnt_d = '0;
    valid_d    = valid_q;
    capture    = 1'b0;
    timer_load = 1'b0;
    o_next     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_enable) begin
          // After reset the reader already presents index 0, so skip the strobe.
          if (first_q) begin
            first_d = 1'b0;
            state_d = StWait;
          end else begin
            timer_load = 1'b1;
            state_d    = StStrobe;
          end
        end
      end
      StStrobe: begin
        o_next  = 1'b1;
        idx_d   = (idx_q == LastIndex) ? '0 : idx_q + ADDR_MODULE'(1);
        state_d = StWait;
      end
      StWait: begin
        if (wait_cnt_q == WaitLast) begin
          capture = 1'b1;
          valid_d = 1'b1;
          state_d = StHold;
        end else begin
          wait_cnt_d = wait_cnt_q + WaitW'(1);
        end
      end
      StHold: begin
        if (i_ready) begin
          valid_d = 1'b0;
          state_d = StGap;
        end
      end
      StGap: begin
        if (timer_elapsed) begin
          if (i_enable) begin
            timer_load = 1'b1;
            state_d    = StStrobe;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= StIdle;
      first_q    <= 1'b1;
      idx_q      <= '0;
      wait_cnt_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      first_q    <= first_d;
      idx_q      <= idx_d;
      wait_cnt_q <= wait_cnt_d;
      valid_q    <= valid_d;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      ref_q  <= '0;
      err_q  <= '0;
      oidx_q <= '0;
    end else if (capture) begin
      ref_q  <= i_reference;
      err_q  <= i_error;
      oidx_q <= idx_q;
    end
  end

  assign o_valid     = valid_q;
  assign o_reference = ref_q;
  assign o_error     = err_q;
  assign o_index     = oidx_q;
  assign o_last      = valid_q && (oidx_q == LastIndex);
  assign o_busy      = (state_q != StIdle);

`ifdef SAMPLE_FETCHER_ERRACC_EN
  localparam int unsigned AccW = DATA_SIZE + ADDR_MODULE;

  logic [AccW-1:0] acc_q;

  // Index 0 starts a new pass over memory, so it reloads rather than adds.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      acc_q <= '0;
    end else if (valid_q && i_ready) begin
      if (oidx_q == '0) begin
        acc_q <= AccW'(err_q);
      end else begin
        acc_q <= acc_q + AccW'(err_q);
      end
    end
  end

  assign o_err_acc = acc_q;
`else
  // No accumulator in this build.
`endif

endmodule

// File: tb/tb_sample_fetcher.sv
// Self-checking bench for sample_fetcher (default parameters).
// Expected samples are queued by the stimulus; a monitor pops and compares
// on every output handshake. Define SAMPLE_FETCHER_ERRACC_EN to also check
// o_err_acc at the index wrap.
module tb_sample_fetcher;

  localparam int unsigned Depth = 7514;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] period = 16'd20;
  logic        ready = 1'b0;
  logic        o_next;
  logic [63:0] i_ref, i_err;
  logic        o_valid;
  logic [63:0] o_ref, o_err;
  logic [12:0] o_index;
  logic        o_last;
  logic        o_busy;
`ifdef SAMPLE_FETCHER_ERRACC_EN
  logic [76:0] o_err_acc;
`endif

  sample_fetcher dut (
    .i_clock     (clk),
    .i_reset     (rst_n),
    .i_enable    (enable),
    .i_period    (period),
    .o_next      (o_next),
    .i_reference (i_ref),
    .i_error     (i_err),
    .o_valid     (o_valid),
    .i_ready     (ready),
    .o_reference (o_ref),
    .o_error     (o_err),
    .o_index     (o_index),
    .o_last      (o_last),
    .o_busy      (o_busy)
`ifdef SAMPLE_FETCHER_ERRACC_EN
    ,
    .o_err_acc   (o_err_acc)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] ref_of(input int unsigned i);
    return 64'hC0DE_0000_0000_0000 ^ (64'(i) * 64'h9E37_79B9);
  endfunction

  function automatic logic [63:0] err_of(input int unsigned i);
    return 64'h0000_1000_0000_0000 + 64'(i) * 64'd3;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: timeout, got no event, expected one (cycle %0d)", name, cyc);
  endtask

  // Upstream reader model: address advances on o_next, data is a pure
  // function of the address.
  int unsigned rd_addr;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_addr <= 0;
    else if (o_next) rd_addr <= (rd_addr == Depth) ? 0 : rd_addr + 1;
  end
  assign i_ref = ref_of(rd_addr);
  assign i_err = err_of(rd_addr);

  typedef struct {
    int unsigned idx;
    logic [63:0] r;
    logic [63:0] e;
    logic        last;
  } exp_t;

  exp_t exp_q[$];

  task automatic push_exp(input int unsigned i);
    exp_t x;
    x.idx  = i;
    x.r    = ref_of(i);
    x.e    = err_of(i);
    x.last = (i == Depth);
    exp_q.push_back(x);
  endtask

  // Monitor: one comparison set per handshake.
  always @(negedge clk) begin
    if (rst_n && o_valid && ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_sample_index", 64'(o_index), 64'hFFFF);
      end else begin
        exp_t x;
        x = exp_q.pop_front();
        check("sample_index", 64'(o_index), 64'(x.idx));
        check("sample_reference", o_ref, x.r);
        check("sample_error", o_err, x.e);
        check("sample_last", 64'(o_last), 64'(x.last));
      end
    end
  end

  // Strobe recorder: cycle of each pulse, and pulses must be one cycle wide.
  int   strobe_q[$];
  logic prev_next = 1'b0;
  always @(negedge clk) begin
    if (o_next) begin
      strobe_q.push_back(cyc);
      check("strobe_width", 64'(prev_next), 64'd0);
    end
    prev_next <= o_next;
  end

  task automatic wait_strobe(input string name);
    bit ok = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (o_next) begin
        ok = 1;
        break;
      end
    end
    if (!ok) timeout(name);
  endtask

  task automatic wait_valid_idx(input int unsigned idx, input int bound, input string name);
    bit ok = 0;
    for (int k = 0; k < bound; k++) begin
      @(negedge clk);
      if (o_valid && o_index == 13'(idx)) begin
        ok = 1;
        break;
      end
    end
    if (!ok) timeout(name);
  endtask

  // First sample after reset: no strobe, valid READ_LATENCY+1 cycles after
  // the FSM leaves IDLE.
  task automatic first_sample(input string name);
    int t0 = 0;
    bit seen_next = 0;
    bit ok = 0;
    push_exp(0);
    @(negedge clk);
    enable = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (o_next) seen_next = 1;
      if (o_busy) begin
        ok = 1;
        t0 = cyc;
        break;
      end
    end
    if (!ok) timeout({name, "_busy"});
    ok = 0;
    for (int k = 0; k < 20; k++) begin
      if (o_valid) begin
        ok = 1;
        break;
      end
      @(negedge clk);
      if (o_next) seen_next = 1;
    end
    if (!ok) timeout({name, "_valid"});
    check({name, "_latency"}, 64'(cyc - t0), 64'd3);
    check({name, "_no_strobe"}, 64'(seen_next), 64'd0);
  endtask

  logic [63:0] hold_ref, hold_err;
  logic [12:0] hold_idx;

  initial begin
    // Reset state, before any clock edge.
    #1;
    check("rst_valid", 64'(o_valid), 64'd0);
    check("rst_busy", 64'(o_busy), 64'd0);
    check("rst_next", 64'(o_next), 64'd0);
    check("rst_last", 64'(o_last), 64'd0);
    check("rst_index", 64'(o_index), 64'd0);
    check("rst_reference", o_ref, 64'd0);
    check("rst_error", o_err, 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Phase A: first sample, period 20, then period change to 1 (clamped to 6)
    // which only takes effect from the next strobe.
    period = 16'd20;
    ready  = 1'b1;
    strobe_q.delete();
    first_sample("first");
    for (int i = 1; i <= 5; i++) push_exp(i);
    wait_strobe("strobe1");
    wait_strobe("strobe2");
    period = 16'd1;
    wait_valid_idx(5, 400, "phase_a_idx5");
    enable = 1'b0;
    repeat (12) @(negedge clk);
    check("a_idle_busy", 64'(o_busy), 64'd0);
    check("a_strobe_count", 64'(strobe_q.size()), 64'd5);
    if (strobe_q.size() >= 5) begin
      check("spacing_1_2", 64'(strobe_q[1] - strobe_q[0]), 64'd20);
      check("spacing_2_3", 64'(strobe_q[2] - strobe_q[1]), 64'd20);
      check("spacing_3_4", 64'(strobe_q[3] - strobe_q[2]), 64'd6);
      check("spacing_4_5", 64'(strobe_q[4] - strobe_q[3]), 64'd6);
    end

    // Phase B: backpressure for 50 cycles, then handshake.
    ready = 1'b0;
    push_exp(6);
    @(negedge clk);
    enable = 1'b1;
    wait_valid_idx(6, 100, "phase_b_idx6");
    hold_ref = o_ref;
    hold_err = o_err;
    hold_idx = o_index;
    repeat (50) begin
      @(negedge clk);
      check("bp_valid", 64'(o_valid), 64'd1);
      check("bp_reference", o_ref, hold_ref);
      check("bp_error", o_err, hold_err);
      check("bp_index", 64'(o_index), 64'(hold_idx));
      check("bp_no_strobe", 64'(o_next), 64'd0);
    end
    push_exp(7);
    @(posedge clk);
    #1 ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("hs_valid_cleared", 64'(o_valid), 64'd0);
    check("hs_gap_no_strobe", 64'(o_next), 64'd0);
    @(negedge clk);
    check("hs_next_strobe", 64'(o_next), 64'd1);
    wait_valid_idx(7, 100, "phase_b_idx7");
    enable = 1'b0;
    repeat (12) @(negedge clk);
    check("b_idle_busy", 64'(o_busy), 64'd0);

    // Phase C: run to the last index and wrap to 0.
    period = 16'd1;
    for (int i = 8; i <= int'(Depth); i++) push_exp(i);
    push_exp(0);
    enable = 1'b1;
    wait_valid_idx(Depth, 60000, "wrap_last");
    check("wrap_o_last", 64'(o_last), 64'd1);
    wait_valid_idx(0, 100, "wrap_zero");
    enable = 1'b0;
    @(negedge clk);
`ifdef SAMPLE_FETCHER_ERRACC_EN
    check("err_acc_low", o_err_acc[63:0], err_of(0));
    check("err_acc_high", 64'(o_err_acc[76:64]), 64'd0);
`endif
    repeat (12) @(negedge clk);
    check("c_idle_busy", 64'(o_busy), 64'd0);

    // Phase D: reset during WAIT, away from any clock edge.
    enable = 1'b1;
    wait_strobe("d_strobe");
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid", 64'(o_valid), 64'd0);
    check("midrst_busy", 64'(o_busy), 64'd0);
    check("midrst_reference", o_ref, 64'd0);
    check("midrst_index", 64'(o_index), 64'd0);
    enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    first_sample("post_rst");
    enable = 1'b0;
    repeat (12) @(negedge clk);
    check("d_idle_busy", 64'(o_busy), 64'd0);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
